// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic skew/deskew stream stage.
package systolic_pkg;

    localparam int unsigned MODE_SKEW   = 0;
    localparam int unsigned MODE_DESKEW = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Beats of delay applied to a lane: i for skew, LANES-1-i for deskew.
    function automatic int unsigned lane_delay(input int unsigned lane,
                                               input int unsigned lanes,
                                               input int unsigned mode);
        return (mode == MODE_DESKEW) ? (lanes - 1 - lane) : lane;
    endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// One lane delay line of {data, valid}; advances only when en is high.
module systolic_skew_lane #(
    parameter int unsigned DEPTH      = 1,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLOCK,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused  = CLOCK ^ reset ^ en ^ clear;
            assign out_data  = in_data;
            assign out_valid = in_valid;
        end else begin : g_shift
            logic [DATA_WIDTH-1:0] r_data [DEPTH];
            logic [DEPTH-1:0]      r_valid;

            always_ff @(posedge CLOCK or posedge reset) begin
                if (reset) begin
                    for (int unsigned k = 0; k < DEPTH; k++) r_data[k] <= '0;
                    r_valid <= '0;
                end else if (clear) begin
                    for (int unsigned k = 0; k < DEPTH; k++) r_data[k] <= '0;
                    r_valid <= '0;
                end else if (en) begin
                    r_data[0]  <= in_data;
                    r_valid[0] <= in_valid;
                    for (int unsigned k = 1; k < DEPTH; k++) begin
                        r_data[k]  <= r_data[k-1];
                        r_valid[k] <= r_valid[k-1];
                    end
                end
            end

            assign out_data  = r_data[DEPTH-1];
            assign out_valid = r_valid[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_skew_stream.sv
// Skew/deskew stage: per-lane delay lines, zero-fill drain after last, and a
// registered output with full valid/ready backpressure.
module systolic_skew_stream
    import systolic_pkg::*;
#(
    parameter int unsigned LANES      = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MODE       = MODE_SKEW
) (
    input  logic                        CLOCK,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [LANES-1:0]            out_lane_valid,
    output logic                        out_valid,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam int unsigned BUS_W = LANES * DATA_WIDTH;
    localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_drain_cnt;
    logic [CNT_W-1:0]   w_drain_cnt_nxt;
    logic               w_last_set;
    logic               w_can_accept;
    logic               w_in_fire;
    logic               w_step;
    logic [BUS_W-1:0]   w_lane_data;
    logic [LANES-1:0]   w_lane_valid;

    assign w_can_accept = !out_valid || out_ready;
    assign in_ready     = w_can_accept && (r_state != DRAIN) && !clear;
    assign w_in_fire    = in_valid && in_ready;
    // Lines only move on step, so input bubbles never disturb lane alignment.
    assign w_step       = w_can_accept && !clear && (w_in_fire || (r_state == DRAIN));
    assign busy         = (r_state != IDLE);

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            localparam int unsigned D = lane_delay(i, LANES, MODE);
            logic [DATA_WIDTH-1:0] w_lane_in;

            assign w_lane_in = w_in_fire ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;

            systolic_skew_lane #(
                .DEPTH      (D),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_lane (
                .CLOCK     (CLOCK),
                .reset     (reset),
                .en        (w_step),
                .clear     (clear),
                .in_data   (w_lane_in),
                .in_valid  (w_in_fire),
                .out_data  (w_lane_data[i*DATA_WIDTH +: DATA_WIDTH]),
                .out_valid (w_lane_valid[i])
            );
        end
    endgenerate

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_last_set      = 1'b0;
        if (clear) begin
            w_state_nxt     = IDLE;
            w_drain_cnt_nxt = '0;
        end else begin
            case (r_state)
                IDLE, STREAM: begin
                    if (w_in_fire) begin
                        if (!in_last) begin
                            w_state_nxt = STREAM;
                        end else if (LANES == 1) begin
                            w_last_set  = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt     = DRAIN;
                            w_drain_cnt_nxt = CNT_W'(LANES - 1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_step) begin
                        w_drain_cnt_nxt = r_drain_cnt - CNT_W'(1);
                        if (r_drain_cnt == CNT_W'(1)) begin
                            w_last_set  = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt     = IDLE;
                    w_drain_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Output register: loads on step, otherwise holds fields and drops valid once consumed.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            out_data       <= '0;
            out_lane_valid <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
        end else if (clear) begin
            out_data       <= '0;
            out_lane_valid <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
        end else if (w_step) begin
            out_data       <= w_lane_data;
            out_lane_valid <= w_lane_valid;
            out_valid      <= 1'b1;
            out_last       <= w_last_set;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_skew_stream.sv
// Randomised bench for systolic_skew_stream: SKEW/DESKEW with 4 lanes and a 1-lane build.
module tb_systolic_skew_stream;

    logic CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    logic        reset;
    logic        sel;
    logic        clear4, in_valid4, in_last4, out_ready4;
    logic [31:0] in_data4;

    logic [31:0] s_out_data, d_out_data;
    logic [3:0]  s_lane_valid, d_lane_valid;
    logic        s_out_valid, d_out_valid, s_out_last, d_out_last;
    logic        s_busy, d_busy, s_in_ready, d_in_ready;

    logic [7:0]  c1_in_data, c1_out_data;
    logic        c1_in_valid, c1_in_last, c1_out_ready, c1_clear;
    logic        c1_in_ready, c1_out_valid, c1_out_last, c1_busy;
    logic [0:0]  c1_lane_valid;

    systolic_skew_stream #(.LANES(4), .DATA_WIDTH(8), .MODE(0)) dut_s (
        .CLOCK(CLOCK), .reset(reset), .clear(clear4 && !sel),
        .in_data(in_data4), .in_valid(in_valid4 && !sel), .in_last(in_last4),
        .in_ready(s_in_ready), .out_data(s_out_data), .out_lane_valid(s_lane_valid),
        .out_valid(s_out_valid), .out_last(s_out_last),
        .out_ready(sel ? 1'b1 : out_ready4), .busy(s_busy));

    systolic_skew_stream #(.LANES(4), .DATA_WIDTH(8), .MODE(1)) dut_d (
        .CLOCK(CLOCK), .reset(reset), .clear(clear4 && sel),
        .in_data(in_data4), .in_valid(in_valid4 && sel), .in_last(in_last4),
        .in_ready(d_in_ready), .out_data(d_out_data), .out_lane_valid(d_lane_valid),
        .out_valid(d_out_valid), .out_last(d_out_last),
        .out_ready(sel ? out_ready4 : 1'b1), .busy(d_busy));

    systolic_skew_stream #(.LANES(1), .DATA_WIDTH(8), .MODE(0)) dut_1 (
        .CLOCK(CLOCK), .reset(reset), .clear(c1_clear),
        .in_data(c1_in_data), .in_valid(c1_in_valid), .in_last(c1_in_last),
        .in_ready(c1_in_ready), .out_data(c1_out_data), .out_lane_valid(c1_lane_valid),
        .out_valid(c1_out_valid), .out_last(c1_out_last),
        .out_ready(c1_out_ready), .busy(c1_busy));

    wire [31:0] m_out_data   = sel ? d_out_data   : s_out_data;
    wire [3:0]  m_lane_valid = sel ? d_lane_valid : s_lane_valid;
    wire        m_out_valid  = sel ? d_out_valid  : s_out_valid;
    wire        m_out_last   = sel ? d_out_last   : s_out_last;
    wire        m_busy       = sel ? d_busy       : s_busy;
    wire        m_in_ready   = sel ? d_in_ready   : s_in_ready;

    int checks;
    int failures;

    logic [31:0] in_beats [16];
    logic [31:0] got_d [$];
    logic [3:0]  got_v [$];
    logic        got_l [$];
    int          first_cycle;
    logic        last_busy;

    // Reference: lane i of output beat t carries input beat t-d(i) when that beat exists.
    function automatic void model_beat(input int t, input int nb, input int mode,
                                       output logic [31:0] data, output logic [3:0] vld,
                                       output logic last);
        data = '0;
        vld  = '0;
        for (int i = 0; i < 4; i++) begin
            int d;
            int b;
            d = (mode == 1) ? (3 - i) : i;
            b = t - d;
            if (b >= 0 && b < nb) begin
                vld[i] = 1'b1;
                data[i*8 +: 8] = in_beats[b][i*8 +: 8];
            end
        end
        last = (t == nb + 2);
    endfunction

    // Drives in_beats[0..nb-1] with optional input gaps and backpressure; collects output beats.
    // bp_mode: 0 = always ready, 1 = ready low for cycles 3..5, 2 = random ready.
    task automatic drive4(input int nb, input int bp_mode, input bit gaps);
        int beat;
        int cycles;
        bit holding;
        logic [31:0] hold_d;
        logic [3:0]  hold_v;
        logic        hold_l;
        beat = 0; cycles = 0; holding = 0;
        hold_d = '0; hold_v = '0; hold_l = 0;
        got_d.delete(); got_v.delete(); got_l.delete();
        first_cycle = -1;
        last_busy = 1'bx;
        while (got_d.size() < nb + 3 && cycles < 2000) begin
            @(negedge CLOCK);
            if (holding) begin
                checks++;
                if (m_out_data !== hold_d || m_lane_valid !== hold_v ||
                    m_out_last !== hold_l || m_out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got=%h/%b/%b exp=%h/%b/%b",
                             cycles, m_out_data, m_lane_valid, m_out_last, hold_d, hold_v, hold_l);
                end
            end
            in_valid4 = (beat < nb) && (!gaps || $urandom_range(0, 2) != 0);
            in_data4  = (beat < nb) ? in_beats[beat] : 32'h0;
            in_last4  = (beat == nb - 1);
            case (bp_mode)
                0:       out_ready4 = 1'b1;
                1:       out_ready4 = !(cycles >= 3 && cycles < 6);
                default: out_ready4 = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            holding = m_out_valid && !out_ready4;
            if (holding) begin
                hold_d = m_out_data; hold_v = m_lane_valid; hold_l = m_out_last;
                checks++;
                if (m_in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", cycles, m_in_ready);
                end
            end
            if (m_out_valid && out_ready4) begin
                got_d.push_back(m_out_data);
                got_v.push_back(m_lane_valid);
                got_l.push_back(m_out_last);
                if (first_cycle < 0) first_cycle = cycles;
                if (m_out_last) last_busy = m_busy;
            end
            if (in_valid4 && m_in_ready) beat++;
            cycles++;
        end
        @(negedge CLOCK);
        in_valid4 = 0; in_last4 = 0; out_ready4 = 1;
        #1;
        checks++;
        if (got_d.size() != nb + 3 || m_out_valid !== 1'b0 || m_busy !== 1'b0) begin
            failures++;
            $display("FAIL stream_end beats=%0d exp=%0d out_valid=%b busy=%b exp=0/0",
                     got_d.size(), nb + 3, m_out_valid, m_busy);
        end
    endtask

    task automatic compare_all(input string name, input int nb, input int mode);
        logic [31:0] ed;
        logic [3:0]  ev;
        logic        el;
        for (int t = 0; t < nb + 3; t++) begin
            model_beat(t, nb, mode, ed, ev, el);
            checks++;
            if (t >= got_d.size()) begin
                failures++;
                $display("FAIL %s missing beat t=%0d exp=%h/%b/%b", name, t, ed, ev, el);
            end else if (got_d[t] !== ed || got_v[t] !== ev || got_l[t] !== el) begin
                failures++;
                $display("FAIL %s t=%0d got=%h/%b/%b exp=%h/%b/%b",
                         name, t, got_d[t], got_v[t], got_l[t], ed, ev, el);
            end
        end
    endtask

    task automatic load_pattern();
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 4; i++)
                in_beats[b][i*8 +: 8] = 8'((b << 4) | i);
    endtask

    task automatic test_reset();
        checks++;
        if (s_out_data !== 0 || s_lane_valid !== 0 || s_out_valid !== 0 || s_out_last !== 0 ||
            s_busy !== 0 || s_in_ready !== 1) begin
            failures++;
            $display("FAIL reset_skew got=%h/%b/%b/%b busy=%b rdy=%b exp=0/0/0/0 busy=0 rdy=1",
                     s_out_data, s_lane_valid, s_out_valid, s_out_last, s_busy, s_in_ready);
        end
        checks++;
        if (d_out_data !== 0 || d_lane_valid !== 0 || d_out_valid !== 0 || d_out_last !== 0 ||
            d_busy !== 0 || d_in_ready !== 1) begin
            failures++;
            $display("FAIL reset_deskew got=%h/%b/%b/%b busy=%b rdy=%b exp=0/0/0/0 busy=0 rdy=1",
                     d_out_data, d_lane_valid, d_out_valid, d_out_last, d_busy, d_in_ready);
        end
        checks++;
        if (c1_out_data !== 0 || c1_out_valid !== 0 || c1_out_last !== 0 ||
            c1_busy !== 0 || c1_in_ready !== 1) begin
            failures++;
            $display("FAIL reset_lanes1 got=%h/%b/%b busy=%b rdy=%b exp=0/0/0 busy=0 rdy=1",
                     c1_out_data, c1_out_valid, c1_out_last, c1_busy, c1_in_ready);
        end
    endtask

    task automatic test_skew_basic();
        logic [3:0] exp_v [7];
        exp_v = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        sel = 0;
        load_pattern();
        drive4(4, 0, 0);
        compare_all("skew_basic", 4, 0);
        for (int t = 0; t < 7 && t < got_v.size(); t++) begin
            checks++;
            if (got_v[t] !== exp_v[t]) begin
                failures++;
                $display("FAIL skew_valid_seq t=%0d got=%b exp=%b", t, got_v[t], exp_v[t]);
            end
        end
        checks++;
        if (first_cycle != 1) begin
            failures++;
            $display("FAIL skew_latency got=%0d exp=1", first_cycle);
        end
        checks++;
        if (last_busy !== 1'b0) begin
            failures++;
            $display("FAIL skew_busy_after_last got=%b exp=0", last_busy);
        end
    endtask

    task automatic test_backpressure();
        sel = 0;
        load_pattern();
        drive4(4, 1, 0);
        compare_all("backpressure", 4, 0);
    endtask

    task automatic test_gaps();
        sel = 0;
        load_pattern();
        drive4(4, 0, 1);
        compare_all("gaps_pattern", 4, 0);
        for (int it = 0; it < 6; it++) begin
            int nb;
            nb = $urandom_range(1, 8);
            for (int b = 0; b < nb; b++) in_beats[b] = $urandom;
            drive4(nb, 2, 1);
            compare_all("gaps_random", nb, 0);
        end
    endtask

    task automatic test_deskew();
        logic [31:0] orig [4];
        logic [31:0] skewed [7];
        logic [3:0]  v;
        logic        l;
        load_pattern();
        for (int b = 0; b < 4; b++) orig[b] = in_beats[b];
        for (int t = 0; t < 7; t++) model_beat(t, 4, 0, skewed[t], v, l);
        for (int t = 0; t < 7; t++) in_beats[t] = skewed[t];
        sel = 1;
        drive4(7, 0, 0);
        compare_all("deskew", 7, 1);
        for (int t = 3; t < 7 && t < got_d.size(); t++) begin
            checks++;
            if (got_d[t] !== orig[t-3] || got_v[t] !== 4'b1111) begin
                failures++;
                $display("FAIL deskew_aligned t=%0d got=%h/%b exp=%h/1111",
                         t, got_d[t], got_v[t], orig[t-3]);
            end
        end
        sel = 0;
    endtask

    task automatic test_flush_in_drain(input bit use_reset);
        sel = 0;
        @(negedge CLOCK);
        in_valid4 = 1; in_data4 = $urandom; in_last4 = 0; out_ready4 = 1;
        @(negedge CLOCK);
        in_data4 = $urandom; in_last4 = 1;
        @(negedge CLOCK);
        in_valid4 = 0; in_last4 = 0;
        #1;
        checks++;
        if (s_busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre_busy got=%b exp=1", s_busy);
        end
        @(negedge CLOCK);
        if (use_reset) begin
            reset = 1;
        end else begin
            clear4 = 1; in_valid4 = 1; in_data4 = 32'hDEADBEEF;
            #1;
            checks++;
            if (s_in_ready !== 1'b0) begin
                failures++;
                $display("FAIL clear_in_ready got=%b exp=0", s_in_ready);
            end
        end
        @(negedge CLOCK);
        reset = 0; clear4 = 0; in_valid4 = 0;
        #1;
        checks++;
        if (s_out_valid !== 0 || s_busy !== 0 || s_in_ready !== 1 || s_out_last !== 0) begin
            failures++;
            $display("FAIL flush_after%0d got valid=%b busy=%b rdy=%b last=%b exp=0/0/1/0",
                     use_reset, s_out_valid, s_busy, s_in_ready, s_out_last);
        end
        for (int b = 0; b < 3; b++) in_beats[b] = $urandom;
        drive4(3, 0, 0);
        compare_all(use_reset ? "post_reset_stream" : "post_clear_stream", 3, 0);
    endtask

    task automatic test_lanes1();
        @(negedge CLOCK);
        c1_in_valid = 1; c1_in_data = 8'hA5; c1_in_last = 1; c1_out_ready = 1;
        #1;
        checks++;
        if (c1_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL lanes1_in_ready got=%b exp=1", c1_in_ready);
        end
        @(negedge CLOCK);
        c1_in_valid = 0; c1_in_last = 0;
        checks++;
        if (c1_out_data !== 8'hA5 || c1_out_valid !== 1 || c1_out_last !== 1 ||
            c1_lane_valid !== 1'b1 || c1_busy !== 0) begin
            failures++;
            $display("FAIL lanes1_beat got=%h/%b/%b/%b busy=%b exp=a5/1/1/1 busy=0",
                     c1_out_data, c1_out_valid, c1_out_last, c1_lane_valid, c1_busy);
        end
        @(negedge CLOCK);
        checks++;
        if (c1_out_valid !== 0 || c1_out_last !== 0 || c1_busy !== 0) begin
            failures++;
            $display("FAIL lanes1_after got=%b/%b busy=%b exp=0/0 busy=0",
                     c1_out_valid, c1_out_last, c1_busy);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        sel = 0; reset = 1; clear4 = 0; in_valid4 = 0; in_last4 = 0; out_ready4 = 1;
        in_data4 = '0;
        c1_in_data = '0; c1_in_valid = 0; c1_in_last = 0; c1_out_ready = 1; c1_clear = 0;
        repeat (2) @(negedge CLOCK);
        reset = 0;
        #1;
        test_reset();
        test_skew_basic();
        test_backpressure();
        test_gaps();
        test_deskew();
        test_flush_in_drain(1'b0);
        test_flush_in_drain(1'b1);
        test_lanes1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
